// File: rtl/reg_file_scoreboard.sv
// Register file with forwarding read ports, a per-register busy scoreboard,
// and dedicated SP, PC and condition-code registers.
module reg_file_scoreboard #(
  parameter int          DATA_W   = 16,
  parameter int          NUM_REGS = 8,
  parameter int          PC_W     = 32,
  parameter int          SP_W     = 32,
  parameter int          CCR_W    = 4,
  parameter int unsigned PC_RESET = 32,
  parameter int unsigned SP_RESET = 2047,
  parameter int unsigned SP_STEP  = 1,
  localparam int         ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              wb0_en,
  input  logic [ADDR_W-1:0] wb0_addr,
  input  logic [DATA_W-1:0] wb0_data,
  input  logic              wb1_en,
  input  logic [ADDR_W-1:0] wb1_addr,
  input  logic [DATA_W-1:0] wb1_data,
  input  logic [1:0]        sp_op,
  input  logic [SP_W-1:0]   sp_load_data,
  output logic [SP_W-1:0]   sp_out,
  input  logic              pc_en,
  input  logic [PC_W-1:0]   pc_next,
  output logic [PC_W-1:0]   pc_out,
  input  logic [CCR_W-1:0]  ccr_mask,
  input  logic [CCR_W-1:0]  ccr_in,
  output logic [CCR_W-1:0]  ccr_out
);

  localparam logic [1:0] SP_HOLD = 2'b00;
  localparam logic [1:0] SP_PUSH = 2'b01;
  localparam logic [1:0] SP_POP  = 2'b10;
  localparam logic [1:0] SP_LOAD = 2'b11;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [SP_W-1:0]     sp_q;
  logic [PC_W-1:0]     pc_q;
  logic [CCR_W-1:0]    ccr_q;

  // Forwarding: wb1 carries the younger result, so it beats wb0 and storage.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    if (wb1_en && wb1_addr == addr)      return wb1_data;
    else if (wb0_en && wb0_addr == addr) return wb0_data;
    else                                 return regs[addr];
  endfunction

  function automatic logic wb_hits(input logic [ADDR_W-1:0] addr);
    return (wb0_en && wb0_addr == addr) || (wb1_en && wb1_addr == addr);
  endfunction

  always_comb begin
    rd_data_a = read_port(rd_addr_a);
    rd_data_b = read_port(rd_addr_b);
    rd_busy_a = busy[rd_addr_a] && !wb_hits(rd_addr_a);
    rd_busy_b = busy[rd_addr_b] && !wb_hits(rd_addr_b);
  end

  // NOTE: the array is reset explicitly because stored values must read as 0
  // after reset; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      // NOTE: non-blocking updates to the same target resolve last-wins, so
      // wb1 after wb0 gives it priority and issue after the clears keeps busy set.
      if (wb0_en) begin
        regs[wb0_addr] <= wb0_data;
        busy[wb0_addr] <= 1'b0;
      end
      if (wb1_en) begin
        regs[wb1_addr] <= wb1_data;
        busy[wb1_addr] <= 1'b0;
      end
      if (issue_valid) busy[issue_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q  <= SP_W'(SP_RESET);
      pc_q  <= PC_W'(PC_RESET);
      ccr_q <= '0;
    end else begin
      case (sp_op)
        SP_PUSH: sp_q <= sp_q - SP_W'(SP_STEP);
        SP_POP:  sp_q <= sp_q + SP_W'(SP_STEP);
        SP_LOAD: sp_q <= sp_load_data;
        default: sp_q <= sp_q;
      endcase
      if (pc_en) pc_q <= pc_next;
      ccr_q <= (ccr_q & ~ccr_mask) | (ccr_in & ccr_mask);
    end
  end

  assign sp_out  = sp_q;
  assign pc_out  = pc_q;
  assign ccr_out = ccr_q;

  logic unused_sp_hold;
  assign unused_sp_hold = (SP_HOLD == 2'b00);

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench for reg_file_scoreboard: forwarding, scoreboard, SP/PC/CCR
// behaviour and reset priority, with hand-computed expectations.
module tb_reg_file_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rd_addr_a, rd_addr_b;
  logic [15:0] rd_data_a, rd_data_b;
  logic        rd_busy_a, rd_busy_b;
  logic        issue_valid;
  logic [2:0]  issue_addr;
  logic        wb0_en, wb1_en;
  logic [2:0]  wb0_addr, wb1_addr;
  logic [15:0] wb0_data, wb1_data;
  logic [1:0]  sp_op;
  logic [31:0] sp_load_data, sp_out;
  logic        pc_en;
  logic [31:0] pc_next, pc_out;
  logic [3:0]  ccr_mask, ccr_in, ccr_out;

  int pass_cnt = 0;
  int total_cnt = 0;

  reg_file_scoreboard dut (
    .clk(clk), .rst(rst),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .sp_op(sp_op), .sp_load_data(sp_load_data), .sp_out(sp_out),
    .pc_en(pc_en), .pc_next(pc_next), .pc_out(pc_out),
    .ccr_mask(ccr_mask), .ccr_in(ccr_in), .ccr_out(ccr_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (actual running, required finished)");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_addr = 0;
    wb0_en = 0; wb0_addr = 0; wb0_data = 0;
    wb1_en = 0; wb1_addr = 0; wb1_data = 0;
    sp_op = 2'b00; sp_load_data = 0;
    pc_en = 0; pc_next = 0;
    ccr_mask = 0; ccr_in = 0;
  endtask

  task automatic test_reset();
    for (int r = 0; r < 8; r++) begin
      rd_addr_a = 3'(r); rd_addr_b = 3'(7 - r);
      #1;
      total_cnt++;
      if (rd_data_a !== 16'h0 || rd_data_b !== 16'h0)
        $display("FAIL reset_data r%0d: got a=%h b=%h, want 0000", r, rd_data_a, rd_data_b);
      else pass_cnt++;
      total_cnt++;
      if (rd_busy_a !== 1'b0 || rd_busy_b !== 1'b0)
        $display("FAIL reset_busy r%0d: got a=%b b=%b, want 0", r, rd_busy_a, rd_busy_b);
      else pass_cnt++;
    end
    total_cnt++;
    if (sp_out !== 32'd2047) $display("FAIL reset_sp: got %0d, want 2047", sp_out);
    else pass_cnt++;
    total_cnt++;
    if (pc_out !== 32'd32) $display("FAIL reset_pc: got %0d, want 32", pc_out);
    else pass_cnt++;
    total_cnt++;
    if (ccr_out !== 4'b0000) $display("FAIL reset_ccr: got %b, want 0000", ccr_out);
    else pass_cnt++;
  endtask

  task automatic test_issue_bypass();
    issue_valid = 1; issue_addr = 3; rd_addr_a = 3;
    #1;
    total_cnt++;
    if (rd_busy_a !== 1'b0) $display("FAIL issue_same_cycle_busy: got %b, want 0", rd_busy_a);
    else pass_cnt++;
    tick();
    issue_valid = 0;
    #1;
    total_cnt++;
    if (rd_busy_a !== 1'b1) $display("FAIL issue_busy_r3: got %b, want 1", rd_busy_a);
    else pass_cnt++;
    wb0_en = 1; wb0_addr = 3; wb0_data = 16'h1234;
    #1;
    total_cnt++;
    if (rd_data_a !== 16'h1234) $display("FAIL wb0_bypass_data: got %h, want 1234", rd_data_a);
    else pass_cnt++;
    total_cnt++;
    if (rd_busy_a !== 1'b0) $display("FAIL wb0_bypass_busy: got %b, want 0", rd_busy_a);
    else pass_cnt++;
    tick();
    wb0_en = 0;
    #1;
    total_cnt++;
    if (rd_data_a !== 16'h1234 || rd_busy_a !== 1'b0)
      $display("FAIL wb0_stored: got data=%h busy=%b, want 1234/0", rd_data_a, rd_busy_a);
    else pass_cnt++;
  endtask

  task automatic test_dual_wb();
    wb0_en = 1; wb0_addr = 5; wb0_data = 16'hAAAA;
    wb1_en = 1; wb1_addr = 5; wb1_data = 16'h5555;
    rd_addr_b = 5;
    #1;
    total_cnt++;
    if (rd_data_b !== 16'h5555) $display("FAIL dual_wb_bypass: got %h, want 5555", rd_data_b);
    else pass_cnt++;
    tick();
    wb1_en = 0; wb0_en = 0;
    #1;
    total_cnt++;
    if (rd_data_b !== 16'h5555) $display("FAIL dual_wb_stored: got %h, want 5555", rd_data_b);
    else pass_cnt++;
    // distinct targets on both ports land independently
    wb0_en = 1; wb0_addr = 6; wb0_data = 16'h0606;
    wb1_en = 1; wb1_addr = 7; wb1_data = 16'h0707;
    tick();
    wb0_en = 0; wb1_en = 0;
    rd_addr_a = 6; rd_addr_b = 7;
    #1;
    total_cnt++;
    if (rd_data_a !== 16'h0606 || rd_data_b !== 16'h0707)
      $display("FAIL dual_wb_split: got a=%h b=%h, want 0606/0707", rd_data_a, rd_data_b);
    else pass_cnt++;
  endtask

  task automatic test_issue_wb_same();
    issue_valid = 1; issue_addr = 2;
    wb1_en = 1; wb1_addr = 2; wb1_data = 16'h0007;
    tick();
    issue_valid = 0; wb1_en = 0; rd_addr_a = 2;
    #1;
    total_cnt++;
    if (rd_data_a !== 16'h0007) $display("FAIL issue_wb_data: got %h, want 0007", rd_data_a);
    else pass_cnt++;
    total_cnt++;
    if (rd_busy_a !== 1'b1) $display("FAIL issue_wb_busy: got %b, want 1", rd_busy_a);
    else pass_cnt++;
    // re-issue to a busy register keeps it busy, then a writeback clears it
    issue_valid = 1; issue_addr = 2;
    tick();
    issue_valid = 0;
    wb0_en = 1; wb0_addr = 2; wb0_data = 16'h0009;
    tick();
    wb0_en = 0;
    #1;
    total_cnt++;
    if (rd_busy_a !== 1'b0 || rd_data_a !== 16'h0009)
      $display("FAIL busy_clear: got busy=%b data=%h, want 0/0009", rd_busy_a, rd_data_a);
    else pass_cnt++;
  endtask

  task automatic test_sp();
    sp_op = 2'b11; sp_load_data = 32'h0;
    #1;
    total_cnt++;
    if (sp_out !== 32'd2047) $display("FAIL sp_load_before_edge: got %h, want 000007ff", sp_out);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (sp_out !== 32'h0) $display("FAIL sp_load: got %h, want 00000000", sp_out);
    else pass_cnt++;
    sp_op = 2'b01; tick();
    total_cnt++;
    if (sp_out !== 32'hFFFF_FFFF) $display("FAIL sp_push_wrap: got %h, want ffffffff", sp_out);
    else pass_cnt++;
    sp_op = 2'b10; tick();
    total_cnt++;
    if (sp_out !== 32'h0) $display("FAIL sp_pop_wrap: got %h, want 00000000", sp_out);
    else pass_cnt++;
    tick();
    sp_op = 2'b00; tick();
    total_cnt++;
    if (sp_out !== 32'h1) $display("FAIL sp_pop_hold: got %h, want 00000001", sp_out);
    else pass_cnt++;
  endtask

  task automatic test_pc();
    pc_en = 1; pc_next = 32'h100; tick();
    pc_en = 0; pc_next = 32'h200; tick();
    total_cnt++;
    if (pc_out !== 32'h100) $display("FAIL pc_load_hold: got %h, want 00000100", pc_out);
    else pass_cnt++;
  endtask

  task automatic test_ccr();
    ccr_mask = 4'b1111; ccr_in = 4'b1010; tick();
    total_cnt++;
    if (ccr_out !== 4'b1010) $display("FAIL ccr_full: got %b, want 1010", ccr_out);
    else pass_cnt++;
    ccr_mask = 4'b0011; ccr_in = 4'b0101; tick();
    total_cnt++;
    if (ccr_out !== 4'b1001) $display("FAIL ccr_masked: got %b, want 1001", ccr_out);
    else pass_cnt++;
    ccr_mask = 4'b0000; ccr_in = 4'b1111; tick();
    total_cnt++;
    if (ccr_out !== 4'b1001) $display("FAIL ccr_hold: got %b, want 1001", ccr_out);
    else pass_cnt++;
  endtask

  task automatic test_reset_priority();
    rst = 1;
    issue_valid = 1; issue_addr = 4;
    wb0_en = 1; wb0_addr = 4; wb0_data = 16'hBEEF;
    sp_op = 2'b01; pc_en = 1; pc_next = 32'hDEAD;
    ccr_mask = 4'b1111; ccr_in = 4'b1111;
    rd_addr_a = 4; rd_addr_b = 5;
    #1;
    total_cnt++;
    if (rd_data_a !== 16'hBEEF) $display("FAIL reset_bypass: got %h, want beef", rd_data_a);
    else pass_cnt++;
    tick();
    rst = 0;
    idle_inputs();
    #1;
    total_cnt++;
    if (rd_data_a !== 16'h0 || rd_data_b !== 16'h0)
      $display("FAIL rst_prio_regs: got a=%h b=%h, want 0000", rd_data_a, rd_data_b);
    else pass_cnt++;
    total_cnt++;
    if (rd_busy_a !== 1'b0) $display("FAIL rst_prio_busy: got %b, want 0", rd_busy_a);
    else pass_cnt++;
    total_cnt++;
    if (sp_out !== 32'd2047 || pc_out !== 32'd32 || ccr_out !== 4'b0)
      $display("FAIL rst_prio_spc: got sp=%0d pc=%0d ccr=%b, want 2047/32/0000", sp_out, pc_out, ccr_out);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1;
    rd_addr_a = 0; rd_addr_b = 0;
    idle_inputs();
    tick();
    tick();
    rst = 0;
    test_reset();
    test_issue_bypass();
    test_dual_wb();
    test_issue_wb_same();
    test_sp();
    test_pc();
    test_ccr();
    test_reset_priority();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/reg_file_scoreboard.md
REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

Interface
REQ-001 Parameter DATA_W, default 16, general-register width.
REQ-002 Parameter NUM_REGS, default 8, general-register count; ADDR_W = clog2(NUM_REGS).
REQ-003 Parameter PC_W and SP_W, default 32 each, PC and SP widths.
REQ-004 Parameter CCR_W, default 4, flag count.
REQ-005 Parameters PC_RESET, default 32, and SP_RESET, default 2047, reset values; SP_STEP, default 1, push/pop step.
REQ-006 clk  in  1  clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 rd_addr_a, rd_addr_b  in  ADDR_W  read-port addresses.
REQ-009 rd_data_a, rd_data_b  out  DATA_W  read data.
REQ-010 rd_busy_a, rd_busy_b  out  1  source register has a pending write.
REQ-011 issue_valid  in  1; issue_addr  in  ADDR_W  destination register of the instruction issued this cycle.
REQ-012 wb0_en  in  1; wb0_addr  in  ADDR_W; wb0_data  in  DATA_W  writeback port 0.
REQ-013 wb1_en  in  1; wb1_addr  in  ADDR_W; wb1_data  in  DATA_W  writeback port 1, the younger result.
REQ-014 sp_op  in  2  00 hold, 01 push (SP-=SP_STEP), 10 pop (SP+=SP_STEP), 11 load; sp_load_data  in  SP_W.
REQ-015 sp_out  out  SP_W  current SP.
REQ-016 pc_en  in  1; pc_next  in  PC_W; pc_out  out  PC_W  current PC.
REQ-017 ccr_mask  in  CCR_W; ccr_in  in  CCR_W; ccr_out  out  CCR_W  flags.

Function
REQ-018 Reads are combinational: if wb1_en and wb1_addr==rd_addr, return wb1_data; else if wb0_en and wb0_addr==rd_addr, return wb0_data; else return the stored register.
REQ-019 At each edge, an enabled writeback stores its data; when wb0 and wb1 target the same register, wb1 is written.
REQ-020 Scoreboard is one busy bit per register, all clear after reset.
REQ-021 issue_valid sets busy[issue_addr] at the edge.
REQ-022 An enabled writeback clears the busy bit of its register at the edge, unless issue_valid targets the same register in that cycle, in which case the bit stays set.
REQ-023 rd_busy_x = busy[rd_addr_x] AND NOT (an enabled writeback to rd_addr_x this cycle). An issue in the same cycle does not raise rd_busy in that cycle.
REQ-024 Issue to an already-busy register is legal and leaves the bit set; stalling on rd_busy is upstream's responsibility.
REQ-025 SP arithmetic is modulo 2^SP_W: push from 0 yields 2^SP_W-SP_STEP; pop from all-ones wraps upward.
REQ-026 sp_op 11 loads sp_load_data; the new SP is visible on sp_out one cycle after the edge.
REQ-027 pc_en=1 loads pc_next at the edge; pc_en=0 holds the PC.
REQ-028 CCR update at each edge: CCR <= (CCR AND NOT ccr_mask) OR (ccr_in AND ccr_mask); mask 0 holds the CCR.
REQ-029 sp_out, pc_out and ccr_out are driven directly from registers (no bypass).

Reset
REQ-030 When rst=1 at an edge, all general registers are set to 0, busy bits to 0, SP to SP_RESET, PC to PC_RESET and CCR to 0.
REQ-031 rst takes priority over every issue, writeback, SP, PC and CCR update in the same cycle.
REQ-032 During reset, read ports still apply the REQ-018 bypass combinationally; after reset, stored values read as 0.

Verification
REQ-033 Reset, then read r0..r7 -> all data 0, all busy 0, sp_out=2047, pc_out=32, ccr_out=0.
REQ-034 Issue r3; next cycle rd_busy_a(r3)=1; wb0 r3=0x1234 -> same-cycle rd_data_a=0x1234 with rd_busy_a=0; next cycle busy 0, data 0x1234.
REQ-035 wb0 r5=0xAAAA and wb1 r5=0x5555 in the same cycle -> rd_data shows 0x5555 that cycle and r5=0x5555 afterward.
REQ-036 Issue r2 and wb1 r2=7 in the same cycle -> r2=7 and busy[r2] remains 1.
REQ-037 Load SP=0, then push -> sp_out=0xFFFFFFFF; then pop twice -> sp_out=1.
REQ-038 CCR=0b1010; ccr_mask=0b0011, ccr_in=0b0101 -> ccr_out=0b1001; rst asserted alongside writes -> all outputs return to reset values.
